core_sequencer: RTL
===================

Name: core_sequencer

Overview:
- Parametrised multi-cycle RV32I control sequencer; successor of the top-level FETCH/EX/MEM/WB state machine.
- Sits between memoryController, instructionDecoder, regfile and alucon.
- Adds over the previous generation:
  - EX->WB short-circuit for non-memory instructions
  - correct next-PC for JALR/branches
  - misalignment, illegal-instruction and bus-timeout traps
  - halt handshake and retired-instruction counter

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_VEC, 32'h0000_0010, PC loaded on any trap.
- INIT_WAIT, 32, cycles spent in CPU_NEVER_INITED before first fetch.
- SHORTCIRCUIT, 1, 1 = non-load/store ops skip CPU_MEM.
- MEM_TIMEOUT, 255, max cycles waiting for instr_valid/data_valid; 0 disables the timeout.
- RETIRE_W, 32, width of the retired counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- halt_req  in  1  request to stop at the next instruction boundary
- halted  out  1  core parked in CPU_HALT
- instr_enable  out  1  fetch request
- instr_addr  out  32  fetch address
- instr_valid  in  1  fetch data valid
- instr_result  in  32  fetched word
- instruction  out  32  latched instruction, to decoder
- dec_op  in  7  decoded opcode
- dec_func  in  10  decoded funct
- dec_imm  in  32  decoded immediate
- dec_oplen  in  2  access size (0 = byte, 1 = half, 2 = word)
- dec_illegal  in  1  decoder flags illegal encoding
- alu_result  in  32  ALU output
- rs2_data  in  32  regfile port 2
- data_enable  out  1  data request
- data_we  out  1  data write
- data_addr  out  32  data address
- data_wdata  out  32  data write value
- data_oplen  out  2  data access size
- data_unsigned  out  1  zero-extend loads
- data_valid  in  1  data access done
- data_result  in  32  load data
- rf_we  out  1  regfile write strobe
- rf_data  out  32  regfile write data
- pc  out  32  current PC
- epc  out  32  PC of last trapping instruction
- trap  out  1  one-cycle trap pulse
- trap_cause  out  3  last trap cause
- retired  out  RETIRE_W  instructions retired

Behaviour:
- Reset values: pc=RESET_PC, instruction=32'h00000013; all enables, rf_we, trap and halted = 0; all data/address outputs, epc, trap_cause and retired = 0; state=CPU_NEVER_INITED. Reset asserted mid-access drops enables immediately.
- CPU_NEVER_INITED: count INIT_WAIT cycles, then go to CPU_FETCH, or CPU_HALT if halt_req.
- CPU_FETCH:
  - instr_enable held high with instr_addr=pc until the cycle instr_valid=1.
  - On that cycle: latch instruction, drop instr_enable next cycle, go to CPU_EX.
- Timeout counter: cleared on entry to CPU_FETCH/CPU_MEM. If it reaches MEM_TIMEOUT without valid: trap BUS_TIMEOUT (cause 4).
- CPU_EX, trap priority highest first:
  - dec_illegal: trap ILLEGAL (cause 1).
  - Load/store with addr misaligned to oplen: trap MISALIGNED_LD (2) / MISALIGNED_ST (3); no data request issued.
- CPU_EX, loads/stores: set data_* outputs, data_enable=1, go to CPU_MEM. Stores drive data_wdata=rs2_data.
- CPU_EX, other ops:
  - rf_data = alu_result, or pc+4 for JAL/JALR.
  - Go to CPU_WB if SHORTCIRCUIT, else CPU_MEM (which passes straight to CPU_WB).
- CPU_EX, next_pc:
  - JAL: pc+imm.
  - JALR: alu_result & ~1.
  - Branch: pc+imm if alu_result[0] != dec_func[0], else pc+4.
  - Others: pc+4. All arithmetic mod 2^32.
- CPU_MEM: data_enable held until data_valid; load result goes to rf_data, then CPU_WB.
- CPU_WB:
  - If next_pc[1:0] != 0: trap MISALIGNED_PC (cause 5).
  - Else: rf_we=1 for one cycle except stores and branches; pc<=next_pc; retired+=1 (wraps at 2^RETIRE_W).
  - Next state: CPU_HALT if halt_req, else CPU_FETCH.
- CPU_TRAP (one cycle):
  - trap=1, epc<=pc, trap_cause latched (held until the next trap), pc<=TRAP_VEC.
  - No rf write, retired unchanged, then CPU_FETCH.
- CPU_HALT: halted=1 while halt_req=1. First cycle halt_req=0: halted=0, go to CPU_FETCH.
- Minimum latency: 4 cycles per ALU op with SHORTCIRCUIT=1 and a same-cycle valid; 5 cycles with SHORTCIRCUIT=0.

Decomposition:
- defs package holds:
  - cpustage_t extended with CPU_TRAP and CPU_HALT
  - trapcause_t enum (values 0–5)
  - opcode constants OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR
- One combinational sub-module, core_nextpc: computes next_pc and both misalignment flags.

Test Plan:
- ADDI x1,x0,5 at pc 0, instr_valid returned 1 cycle after request, SHORTCIRCUIT=1 -> rf_we pulse with rf_data=5, pc=4, retired=1, 5 cycles from FETCH entry.
- BEQ x0,x0,+8 at pc 0x20 -> pc=0x28, no rf_we. BNE with equal operands -> pc=0x24.
- LW at address 0x102 -> no data_enable, trap pulse, trap_cause=2, epc=pc, pc=0x10. LH at 0x102 -> data_enable, data_oplen=1, load completes.
- MEM_TIMEOUT=8, data_valid never asserted -> trap_cause=4 after 8 cycles in CPU_MEM, data_enable deasserted.
- JALR to alu_result=0x41 -> pc=0x40, rf_data=old pc+4. Target 0x42 -> trap_cause=5.
- Assert halt_req mid-instruction -> instruction completes, halted=1, no instr_enable. Release -> fetch resumes at next pc. rst pulsed during CPU_MEM -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/core_sequencer_pkg.sv
// rtl/core_sequencer_pkg.sv - shared stage, trap-cause and opcode definitions for the RV32I sequencer
package core_sequencer_pkg;

    // Sequencer stages, kept as plain 3-bit constants for compatibility with older tooling
    typedef logic [2:0] cpustage_t;
    localparam cpustage_t CPU_NEVER_INITED = 3'd0;
    localparam cpustage_t CPU_FETCH        = 3'd1;
    localparam cpustage_t CPU_EX           = 3'd2;
    localparam cpustage_t CPU_MEM          = 3'd3;
    localparam cpustage_t CPU_WB           = 3'd4;
    localparam cpustage_t CPU_TRAP         = 3'd5;
    localparam cpustage_t CPU_HALT         = 3'd6;

    typedef enum logic [2:0] {
        TRAP_NONE          = 3'd0,
        TRAP_ILLEGAL       = 3'd1,
        TRAP_MISALIGNED_LD = 3'd2,
        TRAP_MISALIGNED_ST = 3'd3,
        TRAP_BUS_TIMEOUT   = 3'd4,
        TRAP_MISALIGNED_PC = 3'd5
    } trapcause_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Access is misaligned when the low address bits are not zero for its size;
    // the unused size encoding 3 is treated like a word access.
    function automatic logic is_misaligned(input logic [31:0] addr, input logic [1:0] oplen);
        case (oplen)
            2'd0:    is_misaligned = 1'b0;
            2'd1:    is_misaligned = addr[0];
            default: is_misaligned = (addr[1:0] != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/core_nextpc.sv
// rtl/core_nextpc.sv - combinational next-PC and load/store misalignment evaluation
module core_nextpc
    import core_sequencer_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [6:0]  op,
    input  logic        branch_inv,
    input  logic [31:0] imm,
    input  logic [1:0]  oplen,
    input  logic [31:0] alu_result,
    output logic [31:0] next_pc,
    output logic        misaligned_ld,
    output logic        misaligned_st
);

    logic mis_access;

    // Branch is taken when the ALU compare bit differs from funct3[0] (BEQ/BNE, BLT/BGE, ...)
    always_comb begin
        next_pc = pc + 32'd4;
        case (op)
            OP_JAL:    next_pc = pc + imm;
            OP_JALR:   next_pc = alu_result & ~32'd1;
            OP_BRANCH: if (alu_result[0] != branch_inv) next_pc = pc + imm;
            default:   next_pc = pc + 32'd4;
        endcase
        mis_access    = is_misaligned(alu_result, oplen);
        misaligned_ld = (op == OP_LOAD)  && mis_access;
        misaligned_st = (op == OP_STORE) && mis_access;
    end

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle RV32I control sequencer with traps, halt and retire count
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0010,
    parameter int unsigned INIT_WAIT    = 32,
    parameter int unsigned SHORTCIRCUIT = 1,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned RETIRE_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                halt_req,
    output logic                halted,
    output logic                instr_enable,
    output logic [31:0]         instr_addr,
    input  logic                instr_valid,
    input  logic [31:0]         instr_result,
    output logic [31:0]         instruction,
    input  logic [6:0]          dec_op,
    input  logic [9:0]          dec_func,
    input  logic [31:0]         dec_imm,
    input  logic [1:0]          dec_oplen,
    input  logic                dec_illegal,
    input  logic [31:0]         alu_result,
    input  logic [31:0]         rs2_data,
    output logic                data_enable,
    output logic                data_we,
    output logic [31:0]         data_addr,
    output logic [31:0]         data_wdata,
    output logic [1:0]          data_oplen,
    output logic                data_unsigned,
    input  logic                data_valid,
    input  logic [31:0]         data_result,
    output logic                rf_we,
    output logic [31:0]         rf_data,
    output logic [31:0]         pc,
    output logic [31:0]         epc,
    output logic                trap,
    output logic [2:0]          trap_cause,
    output logic [RETIRE_W-1:0] retired
);

    cpustage_t   state;
    logic [31:0] cnt;
    logic [31:0] next_pc;
    logic [31:0] next_pc_q;
    logic        mis_ld;
    logic        mis_st;
    logic        is_mem_q;
    logic        no_rf_q;
    trapcause_t  cause_q;
    logic        is_ld;
    logic        is_st;
    logic        is_br;
    logic        is_link;
    logic        init_done;
    logic        timeout_hit;
    logic        unused_func;

    assign is_ld       = (dec_op == OP_LOAD);
    assign is_st       = (dec_op == OP_STORE);
    assign is_br       = (dec_op == OP_BRANCH);
    assign is_link     = (dec_op == OP_JAL) || (dec_op == OP_JALR);
    assign init_done   = (cnt + 32'd1) >= 32'(INIT_WAIT);
    assign timeout_hit = (MEM_TIMEOUT != 0) && ((cnt + 32'd1) >= 32'(MEM_TIMEOUT));
    assign unused_func = ^{dec_func[9:3], dec_func[1]};

    // Fetch request follows the stage directly so reset drops it without waiting for a clock
    assign instr_enable = (state == CPU_FETCH);
    assign instr_addr   = instr_enable ? pc : 32'd0;
    assign halted       = (state == CPU_HALT) && halt_req;

    core_nextpc u_nextpc (
        .pc            (pc),
        .op            (dec_op),
        .branch_inv    (dec_func[0]),
        .imm           (dec_imm),
        .oplen         (dec_oplen),
        .alu_result    (alu_result),
        .next_pc       (next_pc),
        .misaligned_ld (mis_ld),
        .misaligned_st (mis_st)
    );

    // Stage sequencing; effects of WB and TRAP become visible on the cycle after those stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= CPU_NEVER_INITED;
            cnt           <= '0;
            pc            <= RESET_PC;
            instruction   <= NOP_INSTR;
            next_pc_q     <= '0;
            is_mem_q      <= 1'b0;
            no_rf_q       <= 1'b0;
            cause_q       <= TRAP_NONE;
            data_enable   <= 1'b0;
            data_we       <= 1'b0;
            data_addr     <= '0;
            data_wdata    <= '0;
            data_oplen    <= '0;
            data_unsigned <= 1'b0;
            rf_we         <= 1'b0;
            rf_data       <= '0;
            epc           <= '0;
            trap          <= 1'b0;
            trap_cause    <= '0;
            retired       <= '0;
        end else begin
            cnt   <= '0;
            rf_we <= 1'b0;
            trap  <= 1'b0;
            case (state)
                CPU_NEVER_INITED: begin
                    if (init_done) state <= halt_req ? CPU_HALT : CPU_FETCH;
                    else           cnt   <= cnt + 32'd1;
                end
                CPU_FETCH: begin
                    if (instr_valid) begin
                        instruction <= instr_result;
                        state       <= CPU_EX;
                    end else if (timeout_hit) begin
                        cause_q <= TRAP_BUS_TIMEOUT;
                        state   <= CPU_TRAP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                CPU_EX: begin
                    next_pc_q <= next_pc;
                    is_mem_q  <= is_ld || is_st;
                    no_rf_q   <= is_st || is_br;
                    if (dec_illegal) begin
                        cause_q <= TRAP_ILLEGAL;
                        state   <= CPU_TRAP;
                    end else if (mis_ld) begin
                        cause_q <= TRAP_MISALIGNED_LD;
                        state   <= CPU_TRAP;
                    end else if (mis_st) begin
                        cause_q <= TRAP_MISALIGNED_ST;
                        state   <= CPU_TRAP;
                    end else if (is_ld || is_st) begin
                        data_enable   <= 1'b1;
                        data_we       <= is_st;
                        data_addr     <= alu_result;
                        data_wdata    <= is_st ? rs2_data : 32'd0;
                        data_oplen    <= dec_oplen;
                        data_unsigned <= is_ld && dec_func[2];
                        state         <= CPU_MEM;
                    end else begin
                        rf_data <= is_link ? (pc + 32'd4) : alu_result;
                        state   <= (SHORTCIRCUIT != 0) ? CPU_WB : CPU_MEM;
                    end
                end
                CPU_MEM: begin
                    if (!is_mem_q) begin
                        state <= CPU_WB;
                    end else if (data_valid) begin
                        data_enable <= 1'b0;
                        if (!data_we) rf_data <= data_result;
                        state <= CPU_WB;
                    end else if (timeout_hit) begin
                        data_enable <= 1'b0;
                        cause_q     <= TRAP_BUS_TIMEOUT;
                        state       <= CPU_TRAP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                CPU_WB: begin
                    if (next_pc_q[1:0] != 2'b00) begin
                        cause_q <= TRAP_MISALIGNED_PC;
                        state   <= CPU_TRAP;
                    end else begin
                        rf_we   <= !no_rf_q;
                        pc      <= next_pc_q;
                        retired <= retired + RETIRE_W'(1);
                        state   <= halt_req ? CPU_HALT : CPU_FETCH;
                    end
                end
                CPU_TRAP: begin
                    trap       <= 1'b1;
                    epc        <= pc;
                    trap_cause <= cause_q;
                    pc         <= TRAP_VEC;
                    state      <= CPU_FETCH;
                end
                CPU_HALT: begin
                    if (!halt_req) state <= CPU_FETCH;
                end
                default: state <= CPU_NEVER_INITED;
            endcase
        end
    end

endmodule
